// File: rtl/voice_sequencer.sv
// Per-sample voice scheduler for data_path: owns per-key gate/attack/active flags, sweeps all keys on each
// SAMPLE_TICK and emits a saturated 16-bit sample. Define VOICE_COUNT_EN to add the ACTIVE_VOICES output.
module voice_sequencer #(
    parameter int NUM_KEYS = 128,
    parameter int OUT_LSB  = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SAMPLE_TICK,
    input  logic        EV_VALID,
    input  logic        EV_ON,
    input  logic [6:0]  EV_KEY,
    input  logic        NOTE_END,
    input  logic        ATT_OFF,
    input  logic [31:0] TONE,
    output logic [6:0]  KEY,
    output logic        LD_PHASE,
    output logic        LD_AMP,
    output logic        LD_TONE,
    output logic        PHASE_MUX,
    output logic        TONE_MUX,
    output logic        AMP_SEL,
    output logic        NOTE_ON,
    output logic        ATT_ON,
    output logic [15:0] SAMPLE_OUT,
    output logic        SAMPLE_VALID,
    output logic        BUSY,
    output logic        OVERRUN
`ifdef VOICE_COUNT_EN
    ,
    output logic [7:0]  ACTIVE_VOICES
`endif
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [6:0] LAST_KEY  = 7'(NUM_KEYS - 1);
    localparam logic [7:0] KEY_LIMIT = 8'(NUM_KEYS);

    state_t       state_r, state_s;
    logic [6:0]   key_r, key_s;
    logic [127:0] gate_r, att_r, active_r;
    logic [127:0] gate_s, att_s, active_s;
    logic [15:0]  sample_r, sat_s;
    logic         overrun_r;
    logic         busy_s, scan_s, last_key_s;
    logic         cur_active_s, cur_gate_s, cur_att_s;
    logic [1:0]   ev_cmd_s;
    logic         ld_phase_s, ld_amp_s, ld_tone_s, phase_mux_s, tone_mux_s, amp_sel_s;
    logic         note_on_s, att_on_s, valid_s;

    // Clamp the selected TONE window to 16 bits when the bits above it are not pure sign extension
    function automatic logic [15:0] saturate(input logic [31:0] tone);
        logic [31:0] top;
        top = 32'($signed(tone) >>> (OUT_LSB + 15));
        if (top == 32'h0000_0000 || top == 32'hFFFF_FFFF) begin
            saturate = 16'(tone >> OUT_LSB);
        end else if (tone[31]) begin
            saturate = 16'h8000;
        end else begin
            saturate = 16'h7FFF;
        end
    endfunction

    assign busy_s       = (state_r != ST_IDLE);
    assign scan_s       = (state_r == ST_SCAN);
    assign last_key_s   = (key_r == LAST_KEY);
    assign cur_active_s = active_r[key_r];
    assign cur_gate_s   = gate_r[key_r];
    assign cur_att_s    = att_r[key_r];
    assign sat_s        = saturate(TONE);
    assign ev_cmd_s     = {EV_VALID & ({1'b0, EV_KEY} < KEY_LIMIT), EV_ON};

    // Next-state, key sequencing and data_path strobes
    always_comb begin
        state_s     = state_r;
        key_s       = key_r;
        ld_phase_s  = 1'b0;
        ld_amp_s    = 1'b0;
        ld_tone_s   = 1'b0;
        phase_mux_s = 1'b0;
        tone_mux_s  = 1'b0;
        amp_sel_s   = 1'b0;
        note_on_s   = 1'b0;
        att_on_s    = 1'b0;
        valid_s     = 1'b0;
        case (state_r)
            ST_INIT: begin
                ld_amp_s   = 1'b1;
                amp_sel_s  = 1'b1;
                ld_phase_s = 1'b1;
                if (last_key_s) begin
                    state_s = ST_IDLE;
                    key_s   = 7'd0;
                end else begin
                    key_s   = key_r + 7'd1;
                end
            end
            ST_IDLE: begin
                key_s = 7'd0;
                if (SAMPLE_TICK) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ld_tone_s = 1'b1;
                key_s     = 7'd0;
                state_s   = ST_SCAN;
            end
            ST_SCAN: begin
                if (cur_active_s) begin
                    ld_phase_s  = 1'b1;
                    ld_amp_s    = 1'b1;
                    ld_tone_s   = 1'b1;
                    tone_mux_s  = 1'b1;
                    note_on_s   = cur_gate_s;
                    att_on_s    = cur_att_s;
                    // A finished voice is zeroed instead of advanced; its last tone still mixes in
                    phase_mux_s = ~NOTE_END;
                    amp_sel_s   = NOTE_END;
                end else begin
                    ld_phase_s  = 1'b0;
                end
                if (last_key_s) begin
                    state_s = ST_DONE;
                    key_s   = 7'd0;
                end else begin
                    key_s   = key_r + 7'd1;
                end
            end
            ST_DONE: begin
                valid_s = 1'b1;
                key_s   = 7'd0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_INIT;
                key_s   = 7'd0;
            end
        endcase
    end

    // Flag next-state: scan clears are applied first so a same-cycle host event overrides them
    always_comb begin
        gate_s          = gate_r;
        att_s           = att_r;
        active_s        = active_r;
        att_s[key_r]    = att_r[key_r] & ~(scan_s & ATT_OFF);
        active_s[key_r] = active_r[key_r] & ~(scan_s & NOTE_END);
        case (ev_cmd_s)
            2'b11: begin
                gate_s[EV_KEY]   = 1'b1;
                att_s[EV_KEY]    = 1'b1;
                active_s[EV_KEY] = 1'b1;
            end
            2'b10: begin
                gate_s[EV_KEY] = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // State, key index, voice flags, held sample and sticky overrun
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_INIT;
            key_r     <= 7'd0;
            gate_r    <= {128{1'b0}};
            att_r     <= {128{1'b0}};
            active_r  <= {128{1'b0}};
            sample_r  <= 16'd0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            key_r     <= key_s;
            gate_r    <= gate_s;
            att_r     <= att_s;
            active_r  <= active_s;
            overrun_r <= overrun_r | (SAMPLE_TICK & busy_s);
            if (valid_s) begin
                sample_r <= sat_s;
            end else begin
                sample_r <= sample_r;
            end
        end
    end

    // Output drive, held low while RESET is asserted
    always_comb begin
        if (RESET) begin
            KEY          = 7'd0;
            LD_PHASE     = 1'b0;
            LD_AMP       = 1'b0;
            LD_TONE      = 1'b0;
            PHASE_MUX    = 1'b0;
            TONE_MUX     = 1'b0;
            AMP_SEL      = 1'b0;
            NOTE_ON      = 1'b0;
            ATT_ON       = 1'b0;
            SAMPLE_OUT   = 16'd0;
            SAMPLE_VALID = 1'b0;
            BUSY         = 1'b0;
            OVERRUN      = 1'b0;
        end else begin
            KEY          = key_r;
            LD_PHASE     = ld_phase_s;
            LD_AMP       = ld_amp_s;
            LD_TONE      = ld_tone_s;
            PHASE_MUX    = phase_mux_s;
            TONE_MUX     = tone_mux_s;
            AMP_SEL      = amp_sel_s;
            NOTE_ON      = note_on_s;
            ATT_ON       = att_on_s;
            SAMPLE_OUT   = valid_s ? sat_s : sample_r;
            SAMPLE_VALID = valid_s;
            BUSY         = busy_s;
            OVERRUN      = overrun_r;
        end
    end

`ifdef VOICE_COUNT_EN
    logic [7:0] count_r;
    logic [7:0] voices_r;

    // Count active keys across one sweep and publish the total at DONE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_r  <= 8'd0;
            voices_r <= 8'd0;
        end else begin
            case (state_r)
                ST_CLEAR: count_r  <= 8'd0;
                ST_SCAN:  count_r  <= count_r + {7'd0, cur_active_s};
                ST_DONE:  voices_r <= count_r;
                default:  count_r  <= count_r;
            endcase
        end
    end

    assign ACTIVE_VOICES = voices_r;
`endif

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer: one instance at OUT_LSB=16 and one at OUT_LSB=8 sharing all inputs.
module tb_voice_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SAMPLE_TICK = 1'b0;
    logic        EV_VALID = 1'b0;
    logic        EV_ON = 1'b0;
    logic [6:0]  EV_KEY = 7'd0;
    logic        NOTE_END = 1'b0;
    logic        ATT_OFF = 1'b0;
    logic [31:0] TONE = 32'd0;

    logic [6:0]  a_key, b_key;
    logic        a_ld_phase, a_ld_amp, a_ld_tone, a_phase_mux, a_tone_mux, a_amp_sel, a_note_on, a_att_on;
    logic        b_ld_phase, b_ld_amp, b_ld_tone, b_phase_mux, b_tone_mux, b_amp_sel, b_note_on, b_att_on;
    logic        a_valid, a_busy, a_ovr, b_valid, b_busy, b_ovr;
    logic [15:0] a_out, b_out;
    logic [9:0]  a_str, b_str;
`ifdef VOICE_COUNT_EN
    logic [7:0]  a_voices, b_voices;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    bit [127:0] m_gate = '0;
    bit [127:0] m_att = '0;
    bit [127:0] m_active = '0;

    voice_sequencer #(.NUM_KEYS(128), .OUT_LSB(16)) u_a (
        .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .EV_VALID(EV_VALID), .EV_ON(EV_ON),
        .EV_KEY(EV_KEY), .NOTE_END(NOTE_END), .ATT_OFF(ATT_OFF), .TONE(TONE), .KEY(a_key),
        .LD_PHASE(a_ld_phase), .LD_AMP(a_ld_amp), .LD_TONE(a_ld_tone), .PHASE_MUX(a_phase_mux),
        .TONE_MUX(a_tone_mux), .AMP_SEL(a_amp_sel), .NOTE_ON(a_note_on), .ATT_ON(a_att_on),
        .SAMPLE_OUT(a_out), .SAMPLE_VALID(a_valid), .BUSY(a_busy), .OVERRUN(a_ovr)
`ifdef VOICE_COUNT_EN
        , .ACTIVE_VOICES(a_voices)
`endif
    );

    voice_sequencer #(.NUM_KEYS(128), .OUT_LSB(8)) u_b (
        .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .EV_VALID(EV_VALID), .EV_ON(EV_ON),
        .EV_KEY(EV_KEY), .NOTE_END(NOTE_END), .ATT_OFF(ATT_OFF), .TONE(TONE), .KEY(b_key),
        .LD_PHASE(b_ld_phase), .LD_AMP(b_ld_amp), .LD_TONE(b_ld_tone), .PHASE_MUX(b_phase_mux),
        .TONE_MUX(b_tone_mux), .AMP_SEL(b_amp_sel), .NOTE_ON(b_note_on), .ATT_ON(b_att_on),
        .SAMPLE_OUT(b_out), .SAMPLE_VALID(b_valid), .BUSY(b_busy), .OVERRUN(b_ovr)
`ifdef VOICE_COUNT_EN
        , .ACTIVE_VOICES(b_voices)
`endif
    );

    assign a_str = {a_ld_phase, a_ld_amp, a_ld_tone, a_phase_mux, a_tone_mux, a_amp_sel,
                    a_note_on, a_att_on, a_busy, a_valid};
    assign b_str = {b_ld_phase, b_ld_amp, b_ld_tone, b_phase_mux, b_tone_mux, b_amp_sel,
                    b_note_on, b_att_on, b_busy, b_valid};

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge on the first INIT cycle; returns at the negedge of the first IDLE cycle
    task automatic init_sweep();
        for (int k = 0; k < 128; k++) begin
            #1;
            check($sformatf("init k%0d", k), {15'd0, a_key, a_str}, {15'd0, 7'(k), 10'b1100010010});
            @(negedge CLK);
        end
        #1;
        check("idle after init", {15'd0, a_key, a_str}, 32'd0);
        @(negedge CLK);
    endtask

    task automatic note(input logic on, input int key);
        EV_VALID = 1'b1;
        EV_ON    = on;
        EV_KEY   = 7'(key);
        @(negedge CLK);
        EV_VALID = 1'b0;
        if (on) begin
            m_gate[key] = 1'b1;
            m_att[key] = 1'b1;
            m_active[key] = 1'b1;
        end else begin
            m_gate[key] = 1'b0;
        end
    endtask

    // One full sample: tick in IDLE, CLEAR, 128 SCAN cycles, DONE, then the hold check in IDLE
    task automatic sample(input int ne_key, input int ao_key, input int tick_at,
                          input logic [31:0] tone, input logic [15:0] exp_a, input logic [15:0] exp_b);
        logic ne;
        logic [9:0] exp_str;
        SAMPLE_TICK = 1'b1;
        TONE = tone;
        #1;
        check("idle at tick", {15'd0, a_key, a_str}, 32'd0);
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        #1;
        check("clear", {15'd0, a_key, a_str}, {15'd0, 7'd0, 10'b0010000010});
        @(negedge CLK);
        for (int k = 0; k < 128; k++) begin
            ne = (k == ne_key);
            NOTE_END = ne;
            ATT_OFF = (k == ao_key);
            SAMPLE_TICK = (k == tick_at);
            #1;
            if (m_active[k]) begin
                exp_str = {1'b1, 1'b1, 1'b1, ~ne, 1'b1, ne, m_gate[k], m_att[k], 1'b1, 1'b0};
            end else begin
                exp_str = 10'b0000000010;
            end
            check($sformatf("scan k%0d", k), {15'd0, a_key, a_str}, {15'd0, 7'(k), exp_str});
            if (ne) m_active[k] = 1'b0;
            if (k == ao_key) m_att[k] = 1'b0;
            @(negedge CLK);
        end
        NOTE_END = 1'b0;
        ATT_OFF = 1'b0;
        SAMPLE_TICK = 1'b0;
        #1;
        check("done strobes", {15'd0, a_key, a_str}, {15'd0, 7'd0, 10'b0000000011});
        check("done strobes lsb8", {15'd0, b_key, b_str}, {15'd0, 7'd0, 10'b0000000011});
        check("sample lsb16", {16'd0, a_out}, {16'd0, exp_a});
        check("sample lsb8", {16'd0, b_out}, {16'd0, exp_b});
        @(negedge CLK);
        TONE = ~tone;
        #1;
        check("idle after done", {15'd0, a_key, a_str}, 32'd0);
        check("sample hold", {16'd0, a_out}, {16'd0, exp_a});
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        check("reset strobes", {15'd0, a_key, a_str}, 32'd0);
        check("reset misc", {15'd0, a_ovr, a_out}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        init_sweep();

        sample(-1, -1, -1, 32'h0000_0000, 16'h0000, 16'h0000);

        note(1'b1, 60);
        note(1'b1, 0);
        note(1'b1, 127);
        sample(-1, 60, -1, 32'h0001_2345, 16'h0001, 16'h0123);
        sample(-1, -1, -1, 32'h0100_0000, 16'h0100, 16'h7FFF);

        note(1'b0, 60);
        sample(60, -1, -1, 32'hFE00_0000, 16'hFE00, 16'h8000);
        #1;
        check("overrun clear", {31'd0, a_ovr}, 32'd0);
        @(negedge CLK);

        sample(-1, -1, 50, 32'hFFFF_8000, 16'hFFFF, 16'hFF80);
        #1;
        check("overrun set", {30'd0, b_ovr, a_ovr}, 32'd3);
`ifdef VOICE_COUNT_EN
        check("active voices", {24'd0, a_voices}, 32'd2);
`endif
        @(negedge CLK);

        note(1'b1, 5);
        SAMPLE_TICK = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        repeat (21) @(negedge CLK);
        #1;
        check("scan k20 pre-reset", {25'd0, a_key}, 32'd20);
        RESET = 1'b1;
        #1;
        check("mid reset strobes", {15'd0, a_key, a_str}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        m_gate = '0;
        m_att = '0;
        m_active = '0;
        init_sweep();
        #1;
        check("after reset misc", {15'd0, a_ovr, a_out}, 32'd0);
        @(negedge CLK);
        sample(-1, -1, -1, 32'h0000_7F00, 16'h0000, 16'h007F);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
